// File: rtl/dut_vector_driver.sv
`default_nettype none
// ============================================================================
// dut_vector_driver : drives LFSR/counter stimulus into the arithmetic datapath
//                     and compacts the returned responses into a 10-bit MISR.
// Revision: 1.0
// ============================================================================
module dut_vector_driver #(
   parameter int         NUM_VECTORS   = 64,
   parameter int         CAPTURE_DELAY = 0,
   parameter logic [5:0] DEFAULT_SEED  = 6'h01
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               mode,
   input  logic                               seed_load,
   input  logic [5:0]                         seed,
   output logic [5:0]                         stim_data,
   input  logic [9:0]                         resp_data,
   output logic                               busy,
   output logic                               done,
   output logic [9:0]                         signature,
   output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count
);

   localparam int            CW         = $clog2(NUM_VECTORS + 1);
   localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_VECTORS - 1);
   localparam logic [1:0]    DRAIN_LAST = (CAPTURE_DELAY > 0) ? 2'(CAPTURE_DELAY - 1) : 2'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    lfsr_q,  lfsr_d;
   logic [5:0]    stim_q,  stim_d;
   logic [9:0]    sig_q,   sig_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          mode_q,  mode_d;
   logic [1:0]    drain_q, drain_d;

   logic          fold;
   logic [5:0]    seed_fixed;
   logic [5:0]    lfsr_next;

   // An all-zero seed would lock the LFSR, so it is forced to 1.
   assign seed_fixed = (seed == 6'h00) ? 6'h01 : seed;
   assign lfsr_next  = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};

   generate
      if (CAPTURE_DELAY == 0) begin : g_direct
         assign fold = (state_q == S_DRIVE);
      end else begin : g_pipe
         // Bit k set means the vector driven k+1 cycles ago still awaits its fold.
         logic [CAPTURE_DELAY-1:0] vld_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
            end else begin
               vld_q <= CAPTURE_DELAY'({vld_q, (state_q == S_DRIVE)});
            end
         end
         assign fold = vld_q[CAPTURE_DELAY-1];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      stim_d  = stim_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      drain_d = drain_q;

      if (fold) begin
         sig_d = {sig_q[8:0], sig_q[9] ^ sig_q[6]} ^ resp_data;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (seed_load) begin
               lfsr_d = seed_fixed;
            end
            if (start) begin
               state_d = S_DRIVE;
               sig_d   = '0;
               cnt_d   = '0;
               mode_d  = mode;
               stim_d  = mode ? 6'h00 : lfsr_d;
            end
         end
         S_DRIVE: begin
            cnt_d = cnt_q + 1'b1;
            if (!mode_q) begin
               lfsr_d = lfsr_next;
            end
            if (cnt_q == LAST_IDX) begin
               state_d = (CAPTURE_DELAY > 0) ? S_DRAIN : S_DONE;
               drain_d = 2'd0;
            end else begin
               stim_d = mode_q ? (stim_q + 6'd1) : lfsr_next;
            end
         end
         S_DRAIN: begin
            drain_d = drain_q + 2'd1;
            if (drain_q == DRAIN_LAST) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lfsr_q  <= DEFAULT_SEED;
         stim_q  <= 6'h00;
         sig_q   <= 10'h000;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         drain_q <= 2'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         stim_q  <= stim_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         drain_q <= drain_d;
      end
   end

   assign stim_data = stim_q;
   assign signature = sig_q;
   assign vec_count = cnt_q;
   assign busy      = (state_q == S_DRIVE) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dut_vector_driver.sv
`default_nettype none
// Bench for dut_vector_driver: three instances (7 vec/no delay, 3 vec/no delay,
// 64 vec/2-cycle delay) checked against an integer model of LFSR, counter and MISR.
module tb_dut_vector_driver;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int mdl_lfsr_a;

   // Instance A: 7 vectors, direct capture
   logic       start_a, mode_a, seed_load_a, busy_a, done_a, resp_sel_a;
   logic [5:0] seed_a, stim_a;
   logic [9:0] resp_a, sig_a, resp_const_a;
   logic [2:0] cnt_a;

   // Instance B: 64 vectors, 2-stage registered datapath
   logic       start_b, mode_b, seed_load_b, busy_b, done_b, resp_sel_b;
   logic [5:0] seed_b, stim_b;
   logic [9:0] resp_b, sig_b, p1_b, p2_b;
   logic [6:0] cnt_b;

   // Instance C: 3 vectors, response tied to 1
   logic       start_c, mode_c, seed_load_c, busy_c, done_c;
   logic [5:0] seed_c, stim_c;
   logic [9:0] sig_c;
   logic [1:0] cnt_c;

   function automatic logic [9:0] dp(input logic [5:0] v);
      int x;
      x = int'(v);
      return 10'((x * x + 3 * x + 5) % 1024);
   endfunction

   function automatic int lfsr_step(input int x);
      return ((x << 1) & 63) | (((x >> 5) ^ (x >> 4)) & 1);
   endfunction

   function automatic int misr_step(input int s, input int r);
      return (((s << 1) & 1023) | (((s >> 9) ^ (s >> 6)) & 1)) ^ r;
   endfunction

   assign resp_a = resp_sel_a ? dp(stim_a) : resp_const_a;

   always @(posedge clk) begin
      p1_b <= dp(stim_b);
      p2_b <= p1_b;
   end
   assign resp_b = resp_sel_b ? p2_b : 10'h000;

   dut_vector_driver #(.NUM_VECTORS(7), .CAPTURE_DELAY(0), .DEFAULT_SEED(6'h01)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .seed_load(seed_load_a),
      .seed(seed_a), .stim_data(stim_a), .resp_data(resp_a), .busy(busy_a),
      .done(done_a), .signature(sig_a), .vec_count(cnt_a)
   );

   dut_vector_driver #(.NUM_VECTORS(64), .CAPTURE_DELAY(2), .DEFAULT_SEED(6'h01)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .seed_load(seed_load_b),
      .seed(seed_b), .stim_data(stim_b), .resp_data(resp_b), .busy(busy_b),
      .done(done_b), .signature(sig_b), .vec_count(cnt_b)
   );

   dut_vector_driver #(.NUM_VECTORS(3), .CAPTURE_DELAY(0), .DEFAULT_SEED(6'h01)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .seed_load(seed_load_c),
      .seed(seed_c), .stim_data(stim_c), .resp_data(10'h001), .busy(busy_c),
      .done(done_c), .signature(sig_c), .vec_count(cnt_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run on instance A, starting from IDLE or DONE.
   task automatic run_a(input bit md, input bit ld, input logic [5:0] sd,
                        input bit rndr, input bit pulse);
      int ev, es, r;
      start_a = 1'b1; mode_a = md; seed_load_a = ld; seed_a = sd;
      if (ld) mdl_lfsr_a = (sd == 6'h00) ? 1 : int'(sd);
      ev = md ? 0 : mdl_lfsr_a;
      es = 0;
      tick();
      start_a = 1'b0; seed_load_a = 1'b0; mode_a = ~md;
      for (int i = 0; i < 7; i++) begin
         resp_sel_a   = ~rndr;
         resp_const_a = 10'($urandom);
         r = rndr ? int'(resp_const_a) : int'(dp(6'(ev)));
         start_a      = pulse && (i == 3);
         seed_load_a  = pulse && (i == 3);
         seed_a       = 6'($urandom);
         chk("a_stim", stim_a, ev);
         chk("a_cnt",  cnt_a,  i);
         chk("a_sig",  sig_a,  es);
         chk("a_busy", busy_a, 1);
         chk("a_done", done_a, 0);
         es = misr_step(es, r);
         if (!md) mdl_lfsr_a = lfsr_step(mdl_lfsr_a);
         if (i < 6) ev = md ? ((ev + 1) & 63) : mdl_lfsr_a;
         tick();
      end
      start_a = 1'b0; seed_load_a = 1'b0;
      chk("a_end_done", done_a, 1);
      chk("a_end_busy", busy_a, 0);
      chk("a_end_sig",  sig_a,  es);
      chk("a_end_cnt",  cnt_a,  7);
      chk("a_end_stim", stim_a, ev);
      tick();
      chk("a_hold_done", done_a, 1);
      chk("a_hold_sig",  sig_a,  es);
      chk("a_hold_cnt",  cnt_a,  7);
   endtask

   // Runs instance B to completion, returning latency and busy-cycle count.
   task automatic run_b(input bit md, output int lat, output int busy_cnt);
      start_b = 1'b1; mode_b = md;
      tick();
      start_b = 1'b0;
      chk("b_first_sig",  sig_b,  0);
      chk("b_first_done", done_b, 0);
      lat = 1;
      busy_cnt = 0;
      while (done_b !== 1'b1 && lat < 200) begin
         if (busy_b === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int es, lat, bc;
      rst = 1'b1;
      start_a = 0; mode_a = 0; seed_load_a = 0; seed_a = 0; resp_sel_a = 1; resp_const_a = 0;
      start_b = 0; mode_b = 0; seed_load_b = 0; seed_b = 0; resp_sel_b = 0;
      start_c = 0; mode_c = 0; seed_load_c = 0; seed_c = 0;
      mdl_lfsr_a = 1;
      tick();
      tick();
      chk("rst_a_stim", stim_a, 0);
      chk("rst_a_sig",  sig_a,  0);
      chk("rst_a_cnt",  cnt_a,  0);
      chk("rst_a_busy", busy_a, 0);
      chk("rst_a_done", done_a, 0);
      chk("rst_b_busy", busy_b, 0);
      chk("rst_b_sig",  sig_b,  0);
      chk("rst_c_done", done_c, 0);
      rst = 1'b0;
      tick();

      // MISR arithmetic with constant response 1 in counter mode
      start_c = 1'b1; mode_c = 1'b1;
      tick();
      start_c = 1'b0;
      es = 0;
      for (int i = 0; i < 3; i++) begin
         chk("c_sig",  sig_c,  es);
         chk("c_stim", stim_c, i);
         es = misr_step(es, 1);
         tick();
      end
      chk("c_sig_final", sig_c, 10'h007);
      chk("c_cnt",  cnt_c,  3);
      chk("c_done", done_c, 1);

      // Seed 0 loaded alone (becomes 01), then an LFSR run
      seed_load_a = 1'b1; seed_a = 6'h00;
      tick();
      seed_load_a = 1'b0;
      mdl_lfsr_a = 1;
      chk("a_idle_stim", stim_a, 0);
      chk("a_idle_busy", busy_a, 0);
      run_a(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);

      // Restart from DONE: sequence continues, mid-run start/seed_load ignored
      run_a(1'b0, 1'b0, 6'h00, 1'b1, 1'b1);

      // Reset in the middle of DRIVE
      start_a = 1'b1; mode_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_stim", stim_a, 0);
      chk("mid_rst_sig",  sig_a,  0);
      chk("mid_rst_cnt",  cnt_a,  0);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_done", done_a, 0);
      rst = 1'b0;
      mdl_lfsr_a = 1;
      tick();
      tick();
      chk("post_rst_sig",  sig_a,  0);
      chk("post_rst_busy", busy_a, 0);
      chk("post_rst_cnt",  cnt_a,  0);

      // start together with seed_load of 2A in IDLE
      run_a(1'b0, 1'b1, 6'h2A, 1'b0, 1'b0);

      // Randomised runs
      for (int k = 0; k < 6; k++) begin
         run_a(1'($urandom), 1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
      end

      // Instance B: zero responses, 64 counter vectors, 2-cycle capture delay
      resp_sel_b = 1'b0;
      run_b(1'b1, lat, bc);
      chk("b0_latency", lat, 67);
      chk("b0_busy",    bc,  66);
      chk("b0_sig",     sig_b,  0);
      chk("b0_stim",    stim_b, 6'h3F);
      chk("b0_cnt",     cnt_b,  64);

      // Instance B with registered datapath must match the undelayed signature
      resp_sel_b = 1'b1;
      run_b(1'b1, lat, bc);
      es = 0;
      for (int v = 0; v < 64; v++) es = misr_step(es, int'(dp(6'(v))));
      chk("b1_latency", lat, 67);
      chk("b1_busy",    bc,  66);
      chk("b1_sig",     sig_b,  es);
      chk("b1_cnt",     cnt_b,  64);
      tick();
      chk("b1_hold_sig", sig_b, es);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
